// File: rtl/regfile_ctrl.sv
// Access controller for a 16x16 register file built from tristate-bitline rows.
//
// After reset it sweeps INIT_VALUE into every register (busy high), then in RUN it
// decodes the two read ports into one-hot read enables and arbitrates the single write
// port between pipeline writeback (primary) and a debug/load writer (secondary). A
// debug writer denied STARVE_LIMIT consecutive cycles wins over writeback.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rd_en1/2, rd_addr1/2        read-port requests and addresses
//   wb_req, wb_addr, wb_data    writeback request; wb_stall says it was not accepted
//   dbg_req, dbg_addr, dbg_data debug write request; dbg_gnt says it was performed
//   WriteReg, D                 one-hot row write enable and write data to the array
//   ReadEnable1/2               one-hot row read enables for bitline 1 / 2
//   byp1/2                      read address matches this cycle's write; consumer uses D
//   busy                        init sweep in progress
module regfile_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [15:0] INIT_VALUE   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en1,
  input  logic        rd_en2,
  input  logic [3:0]  rd_addr1,
  input  logic [3:0]  rd_addr2,
  input  logic        wb_req,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        wb_stall,
  input  logic        dbg_req,
  input  logic [3:0]  dbg_addr,
  input  logic [15:0] dbg_data,
  output logic        dbg_gnt,
  output logic [15:0] WriteReg,
  output logic [15:0] D,
  output logic [15:0] ReadEnable1,
  output logic [15:0] ReadEnable2,
  output logic        byp1,
  output logic        byp2,
  output logic        busy
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  logic       wr_en;
  logic [3:0] wr_addr;
  logic       starved;

  assign starved = 32'(wait_cnt_q) >= STARVE_LIMIT;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = 4'd0;
    D           = 16'h0000;
    busy        = 1'b0;
    dbg_gnt     = 1'b0;
    wb_stall    = 1'b0;
    ReadEnable1 = 16'h0000;
    ReadEnable2 = 16'h0000;
    byp1        = 1'b0;
    byp2        = 1'b0;

    unique case (state_q)
      StInit: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = init_cnt_q;
        D          = INIT_VALUE;
        wb_stall   = wb_req;
        init_cnt_d = init_cnt_q + 4'd1;
        if (init_cnt_q == 4'd15) begin
          state_d = StRun;
        end
      end
      StRun: begin
        dbg_gnt  = dbg_req & (~wb_req | starved);
        wb_stall = wb_req & dbg_gnt;
        if (dbg_gnt) begin
          wr_en   = 1'b1;
          wr_addr = dbg_addr;
          D       = dbg_data;
        end else if (wb_req) begin
          wr_en   = 1'b1;
          wr_addr = wb_addr;
          D       = wb_data;
        end
        ReadEnable1 = rd_en1 ? (16'h0001 << rd_addr1) : 16'h0000;
        ReadEnable2 = rd_en2 ? (16'h0001 << rd_addr2) : 16'h0000;
        byp1        = rd_en1 & wr_en & (rd_addr1 == wr_addr);
        byp2        = rd_en2 & wr_en & (rd_addr2 == wr_addr);
      end
      default: state_d = StInit;
    endcase

    WriteReg = wr_en ? (16'h0001 << wr_addr) : 16'h0000;

    // Count consecutive denied debug cycles, saturating so the compare never wraps.
    if (dbg_req && !dbg_gnt) begin
      wait_cnt_d = (wait_cnt_q == 4'd15) ? 4'd15 : wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = 4'd0;
    end

    // Reset suppresses any in-flight write and all array-facing activity this cycle.
    if (rst) begin
      busy        = 1'b1;
      WriteReg    = 16'h0000;
      D           = 16'h0000;
      ReadEnable1 = 16'h0000;
      ReadEnable2 = 16'h0000;
      byp1        = 1'b0;
      byp2        = 1'b0;
      dbg_gnt     = 1'b0;
      wb_stall    = wb_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      init_cnt_q <= 4'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl. Includes a behavioural 16x16 array that captures D
// on rows selected by WriteReg, so read-back values come through the real enables.
module tb_regfile_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en1, rd_en2;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        wb_req;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_stall;
  logic        dbg_req;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        dbg_gnt;
  logic [15:0] WriteReg, D, ReadEnable1, ReadEnable2;
  logic        byp1, byp2, busy;

  int unsigned n_checks;
  int unsigned n_errors;
  logic        inv_on;

  logic [15:0] mem [16];

  regfile_ctrl #(
    .STARVE_LIMIT(4),
    .INIT_VALUE  (16'h0000)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en1     (rd_en1),
    .rd_en2     (rd_en2),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .wb_req     (wb_req),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_stall   (wb_stall),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_gnt    (dbg_gnt),
    .WriteReg   (WriteReg),
    .D          (D),
    .ReadEnable1(ReadEnable1),
    .ReadEnable2(ReadEnable2),
    .byp1       (byp1),
    .byp2       (byp2),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: any selected row captures D at the rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (WriteReg[i]) mem[i] <= D;
    end
  end

  function automatic logic [15:0] bitline(input logic [15:0] re);
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (re[i]) v = v | mem[i];
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Enable buses must never have more than one bit set.
  always @(negedge clk) begin
    if (inv_on) begin
      check("onehot_we", 32'($onehot0(WriteReg)), 32'd1);
      check("onehot_re1", 32'($onehot0(ReadEnable1)), 32'd1);
      check("onehot_re2", 32'($onehot0(ReadEnable2)), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en1 = 1'b0; rd_en2 = 1'b0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    wb_req = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
    dbg_req = 1'b0; dbg_addr = 4'd0; dbg_data = 16'h0000;
  endtask

  // Walk the 16 init cycles with a pending writeback and read, then check RUN entry.
  task automatic init_walk();
    idle();
    wb_req = 1'b1; wb_addr = 4'd1; wb_data = 16'hFFFF;
    rd_en1 = 1'b1; rd_addr1 = 4'd4;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("init_we", 32'(WriteReg), 32'(16'h0001 << i));
      check("init_d", 32'(D), 32'h0);
      check("init_busy", 32'(busy), 32'd1);
      check("init_stall", 32'(wb_stall), 32'd1);
      check("init_re1", 32'(ReadEnable1), 32'h0);
      tick();
    end
    idle();
    @(negedge clk);
    check("run_busy", 32'(busy), 32'd0);
    check("run_idle_we", 32'(WriteReg), 32'h0);
  endtask

  task automatic read_check(input logic [3:0] addr, input logic [15:0] exp);
    idle();
    rd_en1 = 1'b1; rd_addr1 = addr;
    rd_en2 = 1'b1; rd_addr2 = addr;
    @(negedge clk);
    check("rd1_val", 32'(bitline(ReadEnable1)), 32'(exp));
    check("rd2_val", 32'(bitline(ReadEnable2)), 32'(exp));
    check("rd_byp1", 32'(byp1), 32'd0);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    inv_on   = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hA5A5;
    idle();
    rst = 1'b1;
    wb_req = 1'b1;
    #1;
    inv_on = 1'b1;

    // Reset-cycle outputs.
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(WriteReg), 32'h0);
    check("rst_d", 32'(D), 32'h0);
    check("rst_re", 32'(ReadEnable1 | ReadEnable2), 32'h0);
    check("rst_byp", 32'({byp1, byp2}), 32'h0);
    check("rst_gnt", 32'(dbg_gnt), 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd1);
    tick();
    rst = 1'b0;

    init_walk();
    for (int a = 0; a < 16; a++) read_check(4'(a), 16'h0000);

    // Writeback with same-cycle read of the target: bypass on port 1 only.
    idle();
    wb_req = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF;
    rd_en1 = 1'b1; rd_addr1 = 4'd5;
    rd_en2 = 1'b1; rd_addr2 = 4'd6;
    @(negedge clk);
    check("wb_we", 32'(WriteReg), 32'h0020);
    check("wb_d", 32'(D), 32'hBEEF);
    check("wb_re1", 32'(ReadEnable1), 32'h0020);
    check("wb_re2", 32'(ReadEnable2), 32'h0040);
    check("wb_byp1", 32'(byp1), 32'd1);
    check("wb_byp2", 32'(byp2), 32'd0);
    check("wb_stall", 32'(wb_stall), 32'd0);
    tick();
    read_check(4'd5, 16'hBEEF);

    // Debug alone is granted immediately.
    idle();
    dbg_req = 1'b1; dbg_addr = 4'd3; dbg_data = 16'h1234;
    @(negedge clk);
    check("dbg_gnt", 32'(dbg_gnt), 32'd1);
    check("dbg_we", 32'(WriteReg), 32'h0008);
    check("dbg_d", 32'(D), 32'h1234);
    tick();
    read_check(4'd3, 16'h1234);

    // Starvation: both writers held on R7; debug wins every fifth cycle.
    idle();
    wb_req = 1'b1; wb_addr = 4'd7; wb_data = 16'h1111;
    dbg_req = 1'b1; dbg_addr = 4'd7; dbg_data = 16'h2222;
    rd_en1 = 1'b1; rd_addr1 = 4'd7;
    begin
      logic [15:0] r7;
      logic        g;
      r7 = 16'h0000;
      for (int k = 0; k < 10; k++) begin
        g = (k % 5 == 4);
        @(negedge clk);
        check("stv_gnt", 32'(dbg_gnt), 32'(g));
        check("stv_stall", 32'(wb_stall), 32'(g));
        check("stv_we", 32'(WriteReg), 32'h0080);
        check("stv_d", 32'(D), g ? 32'h2222 : 32'h1111);
        check("stv_byp1", 32'(byp1), 32'd1);
        check("stv_bitline", 32'(bitline(ReadEnable1)), 32'(r7));
        r7 = g ? 16'h2222 : 16'h1111;
        tick();
      end
    end
    // Writeback retries after losing the same-address grant and wins.
    dbg_req = 1'b0;
    @(negedge clk);
    check("retry_gnt", 32'(dbg_gnt), 32'd0);
    check("retry_d", 32'(D), 32'h1111);
    check("retry_bitline", 32'(bitline(ReadEnable1)), 32'h2222);
    tick();
    read_check(4'd7, 16'h1111);

    // Both ports read R9 with no write.
    idle();
    wb_req = 1'b1; wb_addr = 4'd9; wb_data = 16'h9999;
    tick();
    idle();
    rd_en1 = 1'b1; rd_addr1 = 4'd9;
    rd_en2 = 1'b1; rd_addr2 = 4'd9;
    @(negedge clk);
    check("dual_re1", 32'(ReadEnable1), 32'h0200);
    check("dual_re2", 32'(ReadEnable2), 32'h0200);
    check("dual_byp", 32'({byp1, byp2}), 32'h0);
    check("dual_val", 32'(bitline(ReadEnable2)), 32'h9999);
    tick();

    // Reset during a RUN write suppresses the write.
    idle();
    wb_req = 1'b1; wb_addr = 4'd2; wb_data = 16'h7777;
    rst = 1'b1;
    @(negedge clk);
    check("rrun_we", 32'(WriteReg), 32'h0);
    check("rrun_d", 32'(D), 32'h0);
    check("rrun_stall", 32'(wb_stall), 32'd1);
    tick();
    rst = 1'b0;

    // Reset at init cycle 7 restarts the sweep from register 0.
    idle();
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    @(negedge clk);
    check("rinit_we", 32'(WriteReg), 32'h0);
    check("rinit_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    init_walk();
    read_check(4'd9, 16'h0000);
    read_check(4'd2, 16'h0000);
    read_check(4'd7, 16'h0000);

    inv_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
